mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single SPI memory-controller port (mem_req/mem_ready handshake)
//  among NUM_CH requesters: the CPU core, the debug loader, a DMA engine.
//  Each channel presents a complete access and holds it until acknowledged.
//  Exactly one access is in flight at a time. Selectable round-robin or
//  fixed-priority arbitration.
// PARAMETERS
//  NUM_CH   2   number of requesting channels (>=1)
//  ADDR_W   16  address width
//  DATA_W   8   data width
//  RR_MODE  1   1 = round-robin; 0 = fixed priority (lowest index wins)
// PORTS
//  clk           in   1               system clock
//  reset         in   1               asynchronous, active-high reset
//  ch_req        in   NUM_CH          per-channel access request (level)
//  ch_write      in   NUM_CH          1 = write, 0 = read
//  ch_addr       in   NUM_CH*ADDR_W   packed addresses, ch i at [i*ADDR_W +: ADDR_W]
//  ch_wdata      in   NUM_CH*DATA_W   packed write data
//  ch_ready      out  NUM_CH          one-cycle completion pulse, one-hot
//  ch_rdata      out  DATA_W          read data, valid with ch_ready
//  mem_addr      out  ADDR_W          to memory controller
//  mem_data_out  out  DATA_W          write data to memory controller
//  mem_data_in   in   DATA_W          read data from memory controller
//  mem_read      out  1               mem_req & ~latched write
//  mem_write     out  1               mem_req & latched write
//  mem_req       out  1               access request, held until mem_ready
//  mem_ready     in   1               access complete (from memory controller)
//  grant_id      out  max(1,$clog2(NUM_CH))  channel owning current/last access
//  busy          out  1               state != IDLE
// BEHAVIOUR
//  Reset:
//   - State = IDLE; all outputs 0; RR pointer = NUM_CH-1, so ch0 is first.
//   - Reset mid-access drops mem_req asynchronously and discards the access;
//     the memory controller is reset by the same signal.
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: if any ch_req, pick a winner and latch id, addr, wdata and write
//     into registers. Go to BUSY. mem_req is registered, high from the next
//     cycle. No request: stay in IDLE.
//   - BUSY: mem_req=1. mem_addr, mem_data_out, mem_read and mem_write are
//     stable from the latched values. When mem_ready=1:
//       - On a read, capture mem_data_in into ch_rdata.
//       - Go to DONE. mem_req is 0 from the next cycle.
//   - DONE: ch_ready[id]=1 for exactly this cycle. ch_req is ignored. Go to
//     IDLE.
//  Latency: req sampled in IDLE at cycle T; mem_req high T+1..T+k, where
//   mem_ready arrives at T+k; ch_ready at T+k+1; next grant at T+k+2 at the
//   earliest.
//  Requester rule:
//   - A channel holds req/addr/wdata/write stable until it sees ch_ready.
//   - ch_req high in the cycle after ch_ready counts as a new access.
//   - Dropping ch_req while BUSY does not abort the access: it completes and
//     ch_ready still pulses.
//  Arbitration:
//   - RR_MODE=1: search starts at pointer+1, modulo NUM_CH. The pointer
//     updates to the winner at grant.
//   - RR_MODE=0: lowest-index asserted channel wins; the pointer is unused.
//  Inputs latched at grant: later changes to ch_addr/ch_wdata do not affect
//   the access in flight.
//  ch_rdata:
//   - Updates only on read completion.
//   - Write completions and idle cycles leave it unchanged.
//  mem_ready outside BUSY is ignored: no state change, no ch_ready.
//  Addresses pass through unmodified; no wrap or offset logic.
//  grant_id holds the last winner's id while IDLE.
//  NUM_CH=1 is legal: grant_id is 1 bit wide, constant 0.
// TESTING
//  1. NUM_CH=2. ch0 reads 0x1234; mem_ready at the 3rd BUSY cycle, data 0xA5
//     -> mem_req/mem_read high 3 cycles, mem_addr=0x1234,
//     ch_ready=2'b01 one cycle, ch_rdata=0xA5.
//  2. RR_MODE=1, ch0 and ch1 requests held continuously -> grant_id sequence
//     0,1,0,1; each ch_ready one-hot, never both.
//  3. RR_MODE=0, both requests held -> ch0 granted every time; ch1 granted
//     only after ch0 drops its request.
//  4. ch1 writes 0x3C to 0xFFFF after a read returned 0x5A -> mem_write=1,
//     mem_data_out=0x3C, mem_addr=0xFFFF; ch_rdata remains 0x5A.
//  5. Reset asserted in BUSY -> mem_req=0 without waiting for clk. After
//     release: IDLE, no ch_ready, next grant goes to ch0.
//  6. NUM_CH=4: mem_ready pulsed while IDLE -> no state change. ch3 changes
//     ch_addr mid-BUSY -> mem_addr keeps the latched value.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_port_arbiter : shares one memory-controller port among NUM_CH requesters
// Revision 1.0
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int RR_MODE = 1,
  localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_ready,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data_out,
  input  logic [DATA_W-1:0]          mem_data_in,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic                       mem_req,
  input  logic                       mem_ready,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              grant_en;
  logic              complete;

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   search_base;
  logic [ID_W-1:0]   winner;
  logic              found;

  logic [ID_W-1:0]   grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              req_q;
  logic [DATA_W-1:0] rdata_q;

  // Fixed priority is round-robin with the search always starting after the top channel.
  assign search_base = (RR_MODE != 0) ? rr_ptr : ID_W'(NUM_CH - 1);

  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(search_base) + k) % NUM_CH;
      if (!found && ch_req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    grant_en   = 1'b0;
    complete   = 1'b0;
    case (state)
      S_IDLE: begin
        if (|ch_req) begin
          grant_en   = 1'b1;
          next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          complete   = 1'b1;
          next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= ID_W'(NUM_CH - 1);
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      req_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (grant_en) begin
        grant_q <= winner;
        addr_q  <= ch_addr[int'(winner)*ADDR_W +: ADDR_W];
        wdata_q <= ch_wdata[int'(winner)*DATA_W +: DATA_W];
        write_q <= ch_write[winner];
        req_q   <= 1'b1;
        if (RR_MODE != 0) begin
          rr_ptr <= winner;
        end
      end
      if (complete) begin
        req_q <= 1'b0;
        if (!write_q) begin
          rdata_q <= mem_data_in;
        end
      end
    end
  end

  always_comb begin
    ch_ready = '0;
    if (state == S_DONE) begin
      ch_ready[grant_q] = 1'b1;
    end
  end

  assign ch_rdata     = rdata_q;
  assign mem_addr     = addr_q;
  assign mem_data_out = wdata_q;
  assign mem_req      = req_q;
  assign mem_read     = req_q & ~write_q;
  assign mem_write    = req_q & write_q;
  assign grant_id     = grant_q;
  assign busy         = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter : directed and randomized checks of mem_port_arbiter
// Revision 1.0
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 4-channel round-robin instance
  logic [N-1:0]    req   = '0;
  logic [N-1:0]    wr    = '0;
  logic [N*AW-1:0] addr  = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [DW-1:0]   mdin  = '0;
  logic            mrdy  = 1'b0;
  logic [N-1:0]    rdy;
  logic [DW-1:0]   rdata, mdout;
  logic [AW-1:0]   maddr;
  logic            mrd, mwr, mreq, busy;
  logic [1:0]      gid;

  mem_port_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) u_rr (
    .clk(clk), .reset(reset), .ch_req(req), .ch_write(wr), .ch_addr(addr),
    .ch_wdata(wdata), .ch_ready(rdy), .ch_rdata(rdata), .mem_addr(maddr),
    .mem_data_out(mdout), .mem_data_in(mdin), .mem_read(mrd), .mem_write(mwr),
    .mem_req(mreq), .mem_ready(mrdy), .grant_id(gid), .busy(busy)
  );

  // 2-channel fixed-priority instance
  logic [1:0]    f_req   = '0;
  logic [1:0]    f_wr    = '0;
  logic [31:0]   f_addr  = '0;
  logic [15:0]   f_wdata = '0;
  logic [DW-1:0] f_mdin  = '0;
  logic          f_mrdy  = 1'b0;
  logic [1:0]    f_rdy;
  logic [DW-1:0] f_rdata, f_mdout;
  logic [AW-1:0] f_maddr;
  logic          f_mrd, f_mwr, f_mreq, f_busy;
  logic          f_gid;

  mem_port_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) u_fp (
    .clk(clk), .reset(reset), .ch_req(f_req), .ch_write(f_wr), .ch_addr(f_addr),
    .ch_wdata(f_wdata), .ch_ready(f_rdy), .ch_rdata(f_rdata), .mem_addr(f_maddr),
    .mem_data_out(f_mdout), .mem_data_in(f_mdin), .mem_read(f_mrd), .mem_write(f_mwr),
    .mem_req(f_mreq), .mem_ready(f_mrdy), .grant_id(f_gid), .busy(f_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks transactions by cycle number rather than by state.
  int            cyc = 0;
  int            m_ptr, m_last, m_gcyc, m_end, m_free, m_done;
  bit            m_act, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rdata;

  task automatic model_reset();
    m_ptr   = N - 1;
    m_last  = 0;
    m_act   = 1'b0;
    m_wr    = 1'b0;
    m_gcyc  = -10;
    m_end   = -10;
    m_free  = cyc + 1;
    m_done  = 0;
    m_addr  = '0;
    m_wd    = '0;
    m_rdata = '0;
  endtask

  // Predicts the effect of the coming rising edge from the inputs now applied.
  task automatic model_update();
    int c;
    c = cyc + 1;
    if (!m_act && c >= m_free && req != '0) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (req[idx]) begin
          m_last = idx;
          break;
        end
      end
      m_ptr  = m_last;
      m_act  = 1'b1;
      m_gcyc = c;
      m_addr = addr[m_last*AW +: AW];
      m_wd   = wdata[m_last*DW +: DW];
      m_wr   = wr[m_last];
    end else if (m_act && mrdy) begin
      if (!m_wr) m_rdata = mdin;
      m_act  = 1'b0;
      m_end  = c;
      m_free = c + 2;
      m_done = m_last;
    end
  endtask

  task automatic model_check();
    logic [N-1:0] exp_rdy;
    exp_rdy = (cyc == m_end) ? N'(1 << m_done) : '0;
    check("mem_req",  64'(mreq),  64'(m_act));
    check("busy",     64'(busy),  64'(m_act || cyc == m_end));
    check("ch_ready", 64'(rdy),   64'(exp_rdy));
    check("grant_id", 64'(gid),   64'(m_last));
    check("ch_rdata", 64'(rdata), 64'(m_rdata));
    if (m_act) begin
      check("mem_addr",     64'(maddr), 64'(m_addr));
      check("mem_data_out", 64'(mdout), 64'(m_wd));
      check("mem_read",     64'(mrd),   64'(!m_wr));
      check("mem_write",    64'(mwr),   64'(m_wr));
    end else begin
      check("mem_read_idle",  64'(mrd), 64'd0);
      check("mem_write_idle", 64'(mwr), 64'd0);
    end
  endtask

  task automatic tick();
    model_update();
    @(negedge clk);
    cyc++;
    model_check();
  endtask

  task automatic set_ch(input int ch, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[ch]            = 1'b1;
    wr[ch]             = w;
    addr[ch*AW +: AW]  = a;
    wdata[ch*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req    = '0;
    mrdy   = 1'b0;
    f_req  = '0;
    f_mrdy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("reset_busy",     64'(busy),  64'd0);
    check("reset_mem_req",  64'(mreq),  64'd0);
    check("reset_ch_ready", 64'(rdy),   64'd0);
    check("reset_grant_id", 64'(gid),   64'd0);
    check("reset_ch_rdata", 64'(rdata), 64'd0);
    check("reset_mem_addr", 64'(maddr), 64'd0);
    check("reset_fp_busy",  64'(f_busy), 64'd0);
  endtask

  task automatic wait_grant();
    for (int t = 0; t < 20 && !mreq; t++) tick();
    check("grant_seen", 64'(mreq), 64'd1);
  endtask

  // Holds mem_ready off for lat-1 BUSY cycles, then completes with data d.
  task automatic respond(input int lat, input logic [DW-1:0] d);
    for (int i = 1; i < lat; i++) tick();
    mrdy = 1'b1;
    mdin = d;
    tick();
    mrdy = 1'b0;
    for (int i = 0; i < N; i++) if (rdy[i]) req[i] = 1'b0;
  endtask

  task automatic drain();
    req = '0;
    for (int t = 0; t < 20 && (busy || mreq); t++) begin
      mrdy = mreq;
      tick();
    end
    mrdy = 1'b0;
    check("drain_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, ng;
    logic prev;
    int gseq [4];
    int exp2 [4] = '{0, 1, 0, 1};
    bit pend [N];

    // Read with mem_ready in the third BUSY cycle
    do_reset();
    set_ch(0, 1'b0, 16'h1234, 8'h00);
    wait_grant();
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      hi += int'(mreq & mrd);
      if (i < 2) tick();
    end
    check("t1_mem_addr", 64'(maddr), 64'h1234);
    respond(1, 8'hA5);
    check("t1_req_cycles", 64'(hi), 64'd3);
    check("t1_ch_ready", 64'(rdy), 64'b0001);
    check("t1_ch_rdata", 64'(rdata), 64'hA5);
    tick();
    check("t1_ready_one_cycle", 64'(rdy), 64'd0);

    // Round-robin with ch0 and ch1 held continuously
    do_reset();
    set_ch(0, 1'b0, 16'h0100, 8'h00);
    set_ch(1, 1'b0, 16'h0200, 8'h00);
    ng   = 0;
    prev = 1'b0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      mrdy = mreq;
      mdin = DW'($urandom);
      tick();
      if (mreq && !prev) begin
        gseq[ng] = int'(gid);
        ng++;
      end
      prev = mreq;
    end
    check("t2_grant_count", 64'(ng), 64'd4);
    for (int i = 0; i < 4; i++) check("t2_rr_sequence", 64'(gseq[i]), 64'(exp2[i]));
    drain();

    // Write after a read leaves ch_rdata unchanged
    do_reset();
    set_ch(0, 1'b0, 16'h0040, 8'h00);
    wait_grant();
    respond(2, 8'h5A);
    check("t4_read_data", 64'(rdata), 64'h5A);
    set_ch(1, 1'b1, 16'hFFFF, 8'h3C);
    wait_grant();
    check("t4_mem_write",    64'(mwr),   64'd1);
    check("t4_mem_data_out", 64'(mdout), 64'h3C);
    check("t4_mem_addr",     64'(maddr), 64'hFFFF);
    respond(2, 8'h77);
    check("t4_rdata_kept", 64'(rdata), 64'h5A);
    drain();

    // Asynchronous reset while BUSY
    do_reset();
    set_ch(1, 1'b0, 16'h0555, 8'h00);
    wait_grant();
    tick();
    #2 reset = 1'b1;
    #1;
    check("t5_async_mem_req", 64'(mreq), 64'd0);
    check("t5_async_busy",    64'(busy), 64'd0);
    set_ch(0, 1'b0, 16'h0AAA, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("t5_no_ready", 64'(rdy), 64'd0);
    wait_grant();
    check("t5_first_grant", 64'(gid), 64'd0);
    respond(1, 8'h21);
    drain();

    // mem_ready while idle is ignored; inputs are latched at grant
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mrdy = 1'b1;
      tick();
      check("t6_idle_ready_busy",  64'(busy), 64'd0);
      check("t6_idle_ready_pulse", 64'(rdy),  64'd0);
    end
    mrdy = 1'b0;
    set_ch(3, 1'b0, 16'hBEEF, 8'h11);
    wait_grant();
    check("t6_grant_ch3", 64'(gid), 64'd3);
    addr[3*AW +: AW] = 16'h1111;
    wdata[3*DW +: DW] = 8'hEE;
    tick();
    tick();
    check("t6_addr_latched", 64'(maddr), 64'hBEEF);
    respond(1, 8'h66);
    check("t6_ready_ch3", 64'(rdy),   64'b1000);
    check("t6_rdata",     64'(rdata), 64'h66);
    drain();

    // Fixed priority: ch0 always wins until it drops its request
    do_reset();
    f_req  = 2'b11;
    f_wr   = 2'b00;
    f_addr = {16'h2222, 16'h1111};
    ng     = 0;
    prev   = 1'b0;
    for (int i = 0; i < 80 && ng < 5; i++) begin
      f_mrdy = f_mreq;
      @(negedge clk);
      check("t3_onehot", 64'(f_rdy != 2'b11), 64'd1);
      if (f_rdy[0] && ng == 4) f_req[0] = 1'b0;
      if (f_mreq && !prev) begin
        check((ng < 4) ? "t3_fixed_ch0" : "t3_after_drop_ch1", 64'(f_gid), (ng < 4) ? 64'd0 : 64'd1);
        ng++;
      end
      prev = f_mreq;
    end
    check("t3_grant_count", 64'(ng), 64'd5);
    f_req = '0;
    for (int i = 0; i < 10; i++) begin
      f_mrdy = f_mreq;
      @(negedge clk);
    end
    f_mrdy = 1'b0;
    check("t3_idle", 64'(f_busy), 64'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rdy[i]) begin
          pend[i] = 1'b0;
          req[i]  = 1'b0;
        end
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          set_ch(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
        end
      end
      if (mreq) mrdy = ($urandom_range(0, 2) == 0);
      else      mrdy = ($urandom_range(0, 7) == 0);
      mdin = DW'($urandom);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
